// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small byte FIFO feeding an 8N1/8N2 UART serialiser.
// The line idles high; one idle-high clock separates back-to-back frames.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    i_tx_data,
    input  logic                          i_tx_valid,
    output logic                          o_tx_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT * STOP_BITS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT * STOP_BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        r_state;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [PW:0]   r_count;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_tx, r_done;
    logic          w_push, w_pop;

    assign o_tx_ready   = r_count < (PW+1)'(FIFO_DEPTH);
    assign w_push       = i_tx_valid && o_tx_ready;
    assign w_pop        = (r_state == S_IDLE) && (r_count != '0);
    assign o_tx         = r_tx;
    assign o_busy       = r_state != S_IDLE;
    assign o_done       = r_done;
    assign o_fifo_count = r_count;

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr_ptr] <= i_tx_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push != w_pop) r_count <= w_push ? r_count + (PW+1)'(1) : r_count - (PW+1)'(1);
        end
    end

    // tx is registered: each transition sets the level the line holds next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE:
                    if (w_pop) begin
                        r_shift   <= r_mem[r_rd_ptr];
                        r_clk_cnt <= '0;
                        r_tx      <= 1'b0;
                        r_state   <= S_START;
                    end
                S_START:
                    if (r_clk_cnt == BIT_LAST) begin
                        r_clk_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end else r_clk_cnt <= r_clk_cnt + CW'(1);
                S_DATA:
                    if (r_clk_cnt == BIT_LAST) begin
                        r_clk_cnt <= '0;
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        r_tx      <= (r_bit_cnt == 3'd7) ? 1'b1 : r_shift[1];
                        r_state   <= (r_bit_cnt == 3'd7) ? S_STOP : S_DATA;
                    end else r_clk_cnt <= r_clk_cnt + CW'(1);
                S_STOP:
                    if (r_clk_cnt == STOP_LAST) begin
                        r_clk_cnt <= '0;
                        r_done    <= 1'b1;
                        r_state   <= S_IDLE;
                    end else r_clk_cnt <= r_clk_cnt + CW'(1);
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed checks of uart_tx_fifo against a
// frame-timeline reference model (default instance) plus an 8-clock, 2-stop-bit instance.
module tb_uart_tx_fifo;
    localparam int CPB     = 16;
    localparam int DEPTH   = 4;
    localparam int FRAME   = 10 * CPB;
    localparam int CPB_B   = 8;
    localparam int SB_B    = 2;
    localparam int FRAME_B = (9 + SB_B) * CPB_B;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a_data = 8'h00, b_data = 8'h00;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic       a_ready, a_tx, a_busy, a_done;
    logic       b_ready, b_tx, b_busy, b_done;
    logic [2:0] a_count, b_count;
    logic [6:0] a_vec, b_vec;

    uart_tx_fifo dut_a (
        .clk(clk), .rst_n(rst_n), .i_tx_data(a_data), .i_tx_valid(a_valid),
        .o_tx_ready(a_ready), .o_tx(a_tx), .o_busy(a_busy), .o_done(a_done), .o_fifo_count(a_count)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(4), .STOP_BITS(SB_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_tx_data(b_data), .i_tx_valid(b_valid),
        .o_tx_ready(b_ready), .o_tx(b_tx), .o_busy(b_busy), .o_done(b_done), .o_fifo_count(b_count)
    );

    assign a_vec = {a_tx, a_busy, a_done, a_ready, a_count};
    assign b_vec = {b_tx, b_busy, b_done, b_ready, b_count};

    always #5 clk = ~clk;

    // Reference model: byte queue plus position within the current frame (-1 = idle)
    logic [7:0] m_q[$];
    int         m_t = -1;
    logic [7:0] m_cur = 8'h00;
    bit         m_done = 0, m_pushed = 0;
    int         n_checks = 0, n_errors = 0;

    function automatic logic frame_bit(int t, logic [7:0] b, int cpb);
        if (t < 0 || t >= 9 * cpb) return 1'b1;
        if (t < cpb) return 1'b0;
        return b[t / cpb - 1];
    endfunction

    function automatic logic [6:0] exp_a();
        return {frame_bit(m_t, m_cur, CPB), m_t >= 0, m_done, m_q.size() < DEPTH, 3'(m_q.size())};
    endfunction

    task automatic tick();
        bit push;
        @(posedge clk);
        push = a_valid && (m_q.size() < DEPTH) && rst_n;
        m_pushed = push;
        m_done = 0;
        if (!rst_n) begin
            m_q.delete();
            m_t = -1;
        end else if (m_t < 0) begin
            if (m_q.size() > 0) begin
                m_cur = m_q.pop_front();
                m_t = 0;
            end
        end else if (m_t == FRAME - 1) begin
            m_t = -1;
            m_done = 1;
        end else m_t++;
        if (push) m_q.push_back(a_data);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) begin
            @(posedge clk); #1;
            n_checks++;
            if (a_vec !== 7'b1001000 || b_vec !== 7'b1001000) begin
                n_errors++;
                $display("FAIL reset_hold: a=%b b=%b expected 1001000", a_vec, b_vec);
            end
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (a_vec !== exp_a()) begin
            n_errors++;
            $display("FAIL reset_release: got %b expected %b", a_vec, exp_a());
        end
    endtask

    task automatic test_single();
        int fall = -1, dcyc = -1;
        a_valid = 1'b1; a_data = 8'hA5;
        tick();
        a_valid = 1'b0; a_data = 8'($urandom);
        for (int k = 1; k <= 200; k++) begin
            tick();
            n_checks++;
            if (a_vec !== exp_a()) begin
                n_errors++;
                $display("FAIL single cyc %0d: got %b expected %b", k, a_vec, exp_a());
            end
            if (fall < 0 && !a_tx) fall = k;
            if (dcyc < 0 && a_done) dcyc = k;
        end
        n_checks++;
        if (fall !== 1 || dcyc - fall !== FRAME) begin
            n_errors++;
            $display("FAIL single_timing: fall=%0d done-fall=%0d expected 1 and %0d", fall, dcyc - fall, FRAME);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] sent[3] = '{8'h55, 8'h00, 8'hFF};
        logic [7:0] rx[$];
        logic [7:0] sh = 8'h00;
        logic       prev = 1'b1;
        int         c0 = -1, dones = 0;
        bit         frame_err = 0;
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1; a_data = sent[i];
            tick();
        end
        a_valid = 1'b0;
        for (int c = 1; c <= 700; c++) begin
            tick();
            n_checks++;
            if (a_vec !== exp_a()) begin
                n_errors++;
                $display("FAIL loopback cyc %0d: got %b expected %b", c, a_vec, exp_a());
            end
            if (a_done) dones++;
            if (c0 < 0) begin
                if (prev && !a_tx) c0 = c;
            end else if ((c - c0) % CPB == CPB / 2 && (c - c0) > CPB) begin
                if ((c - c0) / CPB - 1 < 8) sh[(c - c0) / CPB - 1] = a_tx;
                else begin
                    if (!a_tx) frame_err = 1;
                    rx.push_back(sh);
                    c0 = -1;
                end
            end
            prev = a_tx;
        end
        n_checks++;
        if (rx.size() != 3 || dones != 3 || frame_err) begin
            n_errors++;
            $display("FAIL loopback_frames: bytes=%0d dones=%0d frame_err=%0d expected 3 3 0", rx.size(), dones, frame_err);
        end
        for (int i = 0; i < 3 && i < rx.size(); i++) begin
            n_checks++;
            if (rx[i] !== sent[i]) begin
                n_errors++;
                $display("FAIL loopback_byte%0d: got %h expected %h", i, rx[i], sent[i]);
            end
        end
    endtask

    task automatic test_burst();
        logic [7:0] bytes[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        int  idx = 0;
        bit  saw_full = 0;
        a_valid = 1'b1; a_data = bytes[0];
        for (int c = 0; c < 1200; c++) begin
            tick();
            if (m_pushed) idx++;
            a_valid = idx < 6;
            a_data = (idx < 6) ? bytes[idx] : 8'($urandom);
            n_checks++;
            if (a_vec !== exp_a() || a_count > 3'd4) begin
                n_errors++;
                $display("FAIL burst cyc %0d: got %b expected %b", c, a_vec, exp_a());
            end
            if (a_count == 3'd4 && !a_ready) saw_full = 1;
        end
        n_checks++;
        if (!saw_full || idx != 6 || m_t >= 0) begin
            n_errors++;
            $display("FAIL burst_summary: saw_full=%0d pushed=%0d expected 1 6", saw_full, idx);
        end
    endtask

    task automatic test_simul();
        a_valid = 1'b1; a_data = 8'h9E;
        tick();
        a_data = 8'h27;
        tick();
        a_valid = 1'b0;
        n_checks++;
        if (a_count !== 3'd1 || !a_busy) begin
            n_errors++;
            $display("FAIL simul_count: count=%0d busy=%b expected 1 1", a_count, a_busy);
        end
        for (int c = 0; c < 2 * FRAME + 10; c++) begin
            tick();
            n_checks++;
            if (a_vec !== exp_a()) begin
                n_errors++;
                $display("FAIL simul cyc %0d: got %b expected %b", c, a_vec, exp_a());
            end
        end
    endtask

    task automatic test_reset_mid();
        a_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_data = (i == 0) ? 8'h3C : 8'($urandom);
            tick();
        end
        a_valid = 1'b0;
        for (int c = 0; c < 400 && m_t != 4 * CPB + 5; c++) tick();
        n_checks++;
        if (m_t != 4 * CPB + 5 || a_tx !== frame_bit(m_t, m_cur, CPB) || a_count !== 3'd2) begin
            n_errors++;
            $display("FAIL reset_mid_setup: tx=%b count=%0d expected %b 2", a_tx, a_count, frame_bit(m_t, m_cur, CPB));
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (a_vec !== 7'b1001000) begin
            n_errors++;
            $display("FAIL reset_mid_async: got %b expected 1001000", a_vec);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            tick();
            n_checks++;
            if (a_vec !== 7'b1001000 || a_vec !== exp_a()) begin
                n_errors++;
                $display("FAIL reset_mid_idle cyc %0d: got %b expected 1001000", c, a_vec);
            end
        end
        a_valid = 1'b1; a_data = 8'($urandom);
        tick();
        a_valid = 1'b0;
        for (int c = 0; c < FRAME + 5; c++) begin
            tick();
            n_checks++;
            if (a_vec !== exp_a()) begin
                n_errors++;
                $display("FAIL reset_mid_resume cyc %0d: got %b expected %b", c, a_vec, exp_a());
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            a_valid = ($urandom_range(0, 99) < 3);
            a_data = 8'($urandom);
            tick();
            n_checks++;
            if (a_vec !== exp_a()) begin
                n_errors++;
                $display("FAIL random cyc %0d: got %b expected %b", c, a_vec, exp_a());
            end
        end
        a_valid = 1'b0;
        for (int c = 0; c < 5 * (FRAME + 1) && (m_t >= 0 || m_q.size() > 0); c++) tick();
    endtask

    task automatic test_stop2();
        logic [6:0] expb;
        int fall = -1, dcyc = -1, t;
        b_valid = 1'b1; b_data = 8'h81;
        tick();
        b_valid = 1'b0; b_data = 8'($urandom);
        for (int k = 1; k <= 100; k++) begin
            tick();
            t = (k - 1 < FRAME_B) ? k - 1 : -1;
            expb = {frame_bit(t, 8'h81, CPB_B), t >= 0, k == FRAME_B + 1, 1'b1, 3'd0};
            n_checks++;
            if (b_vec !== expb) begin
                n_errors++;
                $display("FAIL stop2 cyc %0d: got %b expected %b", k, b_vec, expb);
            end
            if (fall < 0 && !b_tx) fall = k;
            if (dcyc < 0 && b_done) dcyc = k;
        end
        n_checks++;
        if (dcyc - fall !== FRAME_B) begin
            n_errors++;
            $display("FAIL stop2_timing: done-fall=%0d expected %0d", dcyc - fall, FRAME_B);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_loopback();
        test_burst();
        test_simul();
        test_reset_mid();
        test_random();
        test_stop2();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
